// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART receive path: the
//               receiver state encoding, default oversampling ratio and the
//               data-width code decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // rx_tick pulses per bit period
    localparam int OVERSAMPLE_DEF = 16;

    // Map the 2-bit width code onto a data bit count: 00=5 .. 11=8
    function automatic logic [3:0] width_to_bits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial line.
//               Resets to 1 so an idle-high line does not look like a start
//               bit while coming out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] sync_q;

    // Shift the raw line through two flops to settle metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_async};
        end
    end

    assign o_sync = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : Oversampling asynchronous serial receiver. Deframes
//               start / 5-8 data bits (LSB first) / optional parity / stop
//               and presents the word with a one-clock done strobe and a
//               parity-error flag.
//               Build option UART_RX_SYNC_EN: route i_rx_serial through a
//               2-flop synchronizer before the FSM; otherwise the line is
//               sampled directly and must already be synchronous.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_tick,
    input  logic [1:0] i_num_bit_data,
    input  logic       i_parity_en,
    input  logic       i_parity_type,
    input  logic       i_rx_serial,
    output logic [7:0] o_data,
    output logic       o_rx_done,
    output logic       o_parity_err
);

    localparam int                CNT_W     = $clog2(OVERSAMPLE);
    // Tick count at the middle of the start bit; every later sample is one
    // full bit period after the previous one, so it also lands mid-bit.
    localparam logic [CNT_W-1:0]  MID_TICK  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(OVERSAMPLE - 1);

    logic             w_rx_line;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_rx_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_rx_serial),
        .o_sync  (w_rx_line)
    );
`else
    assign w_rx_line = i_rx_serial;
`endif

    rx_state_t        state_q,    state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [7:0]       shift_q,    shift_d;
    logic [3:0]       nbits_q,    nbits_d;
    logic             par_en_q,   par_en_d;
    logic             par_type_q, par_type_d;
    logic             perr_q,     perr_d;
    logic [7:0]       data_q,     data_d;
    logic             done_q,     done_d;
    logic             par_err_q,  par_err_d;

    logic [7:0]       w_mask;
    logic             w_data_xor;

    // Keep only the bits that belong to the current frame width
    assign w_mask     = 8'hFF >> (4'd8 - nbits_q);
    assign w_data_xor = ^(shift_q & w_mask);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            nbits_q    <= 4'd8;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            par_err_q  <= par_err_d;
        end
    end

    // Next-state logic: everything advances on rx_tick except the done
    // strobe, which defaults low so it lasts exactly one clock.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        perr_d     = perr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        par_err_d  = par_err_q;

        if (rx_tick) begin
            case (state_q)
                IDLE: begin
                    if (!w_rx_line) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                        perr_d     = 1'b0;
                        // Frame format is frozen here for the whole frame
                        nbits_d    = width_to_bits(i_num_bit_data);
                        par_en_d   = i_parity_en;
                        par_type_d = i_parity_type;
                    end
                end

                START: begin
                    if (tick_cnt_q == MID_TICK) begin
                        if (!w_rx_line) begin
                            tick_cnt_d = '0;
                            bit_idx_d  = '0;
                            state_d    = DATA;
                        end else begin
                            // Line went back high: treat as noise
                            state_d    = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d         = '0;
                        shift_d[bit_idx_q] = w_rx_line;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if ({1'b0, bit_idx_q} == nbits_q - 4'd1) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end

                PARITY: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = '0;
                        perr_d     = w_rx_line != (w_data_xor ^ par_type_q);
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end

                STOP: begin
                    // Stop level is not checked; leaving at mid stop bit
                    // leaves half a bit to catch a back-to-back start edge.
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = '0;
                        data_d     = shift_q & w_mask;
                        par_err_d  = par_en_q & perr_q;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign o_data       = data_q;
    assign o_rx_done    = done_q;
    assign o_parity_err = par_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Self-checking bench for uart_rx_core. A serial driver builds
//               frames from the frame rules and queues the expected word and
//               parity flag; a monitor pops and compares on each done strobe.
//               The tick divider is shortened (tick every 4 clk) to keep the
//               run short; the receiver only sees tick counts.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int CLK_HALF = 10;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_tick = 1'b0;
    logic [1:0] num_bit_data = 2'b11;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_parity_err;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    int   n_sent   = 0;

    uart_rx_core dut (
        .clk            (clk),
        .rst            (rst),
        .rx_tick        (rx_tick),
        .i_num_bit_data (num_bit_data),
        .i_parity_en    (parity_en),
        .i_parity_type  (parity_type),
        .i_rx_serial    (rx_serial),
        .o_data         (o_data),
        .o_rx_done      (o_rx_done),
        .o_parity_err   (o_parity_err)
    );

    always #CLK_HALF clk = ~clk;

    // One-clock tick every TICK_DIV clocks
    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 rx_tick = 1'b1;
            @(posedge clk);
            #1 rx_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Pops one expectation per done strobe; a strobe held two clocks or a
    // strobe with nothing queued shows up as a failed check.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_rx_done === 1'b1) begin
                n_done++;
                check("done_has_expectation", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("data", 32'(o_data), 32'(e.data));
                    check("parity_err", 32'(o_parity_err), 32'(e.perr));
                end
            end
        end
    endtask

    task automatic hold_line(input logic level, input int clocks);
        rx_serial = level;
        repeat (clocks) @(posedge clk);
        #1;
    endtask

    // Send one frame. pflip inverts the correct parity bit; scramble
    // randomizes the config inputs once the start bit is on the wire.
    task automatic send_frame(input int nbits, input logic [7:0] data, input logic pen,
                              input logic ptype, input logic pflip, input int stops,
                              input logic scramble);
        exp_t       e;
        logic [7:0] word;
        logic       req;
        logic       sent;
        word = data & 8'((1 << nbits) - 1);
        // Even parity makes the total count of ones even; odd makes it odd
        req  = (($countones(word) % 2) == 1) ^ ptype;
        sent = req ^ pflip;
        e.data = word;
        e.perr = pen && (sent != req);
        exp_q.push_back(e);
        n_sent++;

        num_bit_data = 2'(nbits - 5);
        parity_en    = pen;
        parity_type  = ptype;
        hold_line(1'b0, BIT_CLK);
        if (scramble) begin
            num_bit_data = 2'($urandom_range(0, 3));
            parity_en    = 1'($urandom_range(0, 1));
            parity_type  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < nbits; i++) hold_line(data[i], BIT_CLK);
        if (pen) hold_line(sent, BIT_CLK);
        hold_line(1'b1, stops * BIT_CLK);
    endtask

    initial begin
        int snap;
        fork
            monitor();
        join_none

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_data", 32'(o_data), 32'h0);
        check("reset_done", 32'(o_rx_done), 32'h0);
        check("reset_perr", 32'(o_parity_err), 32'h0);
        rst = 1'b0;
        hold_line(1'b1, 2 * BIT_CLK);

        // Widths 5..8, no parity
        send_frame(5, 8'h1F, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        send_frame(6, 8'h2A, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        send_frame(7, 8'h55, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        send_frame(8, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        // Stale upper bits from the 0xFF frame must not leak into a 5-bit word
        send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        send_frame(5, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        // Even and odd parity, correct and inverted
        send_frame(8, 8'h03, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        send_frame(8, 8'h03, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8, 8'h03, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        send_frame(8, 8'h03, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        // Two stop bits
        send_frame(8, 8'hAA, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        send_frame(8, 8'h55, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        // Back-to-back, no gap
        send_frame(8, 8'h55, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        send_frame(8, 8'hAA, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        hold_line(1'b1, BIT_CLK);

        // Quarter-bit glitch must not start a frame
        snap = n_done;
        hold_line(1'b0, BIT_CLK / 4);
        hold_line(1'b1, 2 * BIT_CLK);
        check("glitch_no_done", 32'(n_done), 32'(snap));

        // Reset in the middle of a frame aborts it
        snap = n_done;
        num_bit_data = 2'b11;
        parity_en    = 1'b0;
        hold_line(1'b0, BIT_CLK);
        hold_line(1'b1, BIT_CLK);
        hold_line(1'b0, BIT_CLK);
        hold_line(1'b1, BIT_CLK / 2);
        #7 rst = 1'b1;
        #33 rst = 1'b0;
        @(posedge clk);
        #1;
        hold_line(1'b1, 10 * BIT_CLK);
        check("abort_no_done", 32'(n_done), 32'(snap));
        check("abort_data_cleared", 32'(o_data), 32'h0);

        // Randomized frames with random gaps and mid-frame config churn
        for (int k = 0; k < 24; k++) begin
            int   nb;
            logic pen;
            nb  = 5 + int'($urandom_range(0, 3));
            pen = 1'($urandom_range(0, 1));
            send_frame(nb, 8'($urandom), pen, 1'($urandom_range(0, 1)),
                       pen & 1'($urandom_range(0, 1)), 1 + int'($urandom_range(0, 1)), 1'b1);
            hold_line(1'b1, int'($urandom_range(0, BIT_CLK)));
        end

        hold_line(1'b1, 2 * BIT_CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_sent));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
